// File: rtl/div_iter_unit.sv
// Iterative restoring divider for RV32M/RV64M DIV/DIVU/REM/REMU.
// Retires BITS_PER_CYCLE quotient bits per cycle; trivial cases finish on a short path.
module div_iter_unit #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1,
  parameter bit FAST_PATH      = 1'b1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic            kill_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int NCYC = XLEN / BITS_PER_CYCLE;
  localparam int CW   = $clog2(NCYC + 1);
  localparam logic [CW-1:0]   CNT_LOAD = CW'(NCYC);
  localparam logic [CW-1:0]   CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0] ONE      = {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0] MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] ZERO     = {XLEN{1'b0}};

  if (!(BITS_PER_CYCLE == 1 || BITS_PER_CYCLE == 2 || BITS_PER_CYCLE == 4) ||
      (XLEN % BITS_PER_CYCLE) != 0) begin : g_bad_param
    $error("div_iter_unit: BITS_PER_CYCLE must be 1, 2 or 4 and divide XLEN");
  end

  typedef enum logic [1:0] {
    D_IDLE = 2'd0,
    D_INIT = 2'd1,
    D_CALC = 2'd2,
    D_SIGN = 2'd3
  } div_states_e;

  div_states_e     r_state;
  div_states_e     w_state_nxt;
  logic [1:0]      r_op;
  logic [XLEN-1:0] r_a;
  logic [XLEN-1:0] r_b;
  logic [XLEN-1:0] r_q;
  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_dvs;
  logic [CW-1:0]   r_cnt;
  logic            r_neg_q;
  logic            r_neg_r;
  logic            r_special;
  logic [XLEN-1:0] r_result;
  logic            r_done;

  logic            w_signed;
  logic            w_a_neg;
  logic            w_b_neg;
  logic [XLEN-1:0] w_abs_a;
  logic [XLEN-1:0] w_abs_b;
  logic            w_b_zero;
  logic            w_ovf;
  logic            w_fast;
  logic            w_short;
  logic [XLEN-1:0] w_sel_q;
  logic [XLEN-1:0] w_sel_r;
  logic [XLEN-1:0] w_result;

  // Operand classification, evaluated while in D_INIT on the captured operands
  assign w_signed = ~r_op[0];
  assign w_a_neg  = w_signed & r_a[XLEN-1];
  assign w_b_neg  = w_signed & r_b[XLEN-1];
  assign w_abs_a  = w_a_neg ? (~r_a + ONE) : r_a;
  assign w_abs_b  = w_b_neg ? (~r_b + ONE) : r_b;
  assign w_b_zero = (r_b == ZERO);
  assign w_ovf    = w_signed & (r_a == MIN_INT) & (r_b == ALL_ONES);
  assign w_fast   = FAST_PATH & (w_abs_a < w_abs_b);
  assign w_short  = w_b_zero | w_ovf | w_fast;

  logic [BITS_PER_CYCLE:0][XLEN-1:0] w_rem_a;
  logic [BITS_PER_CYCLE:0][XLEN-1:0] w_q_a;

  assign w_rem_a[0] = r_rem;
  assign w_q_a[0]   = r_q;

  // Chained restoring steps; the top bit of the XLEN+1-bit difference is the borrow
  for (genvar g = 0; g < BITS_PER_CYCLE; g++) begin : g_step
    logic [XLEN:0] w_sh;
    logic [XLEN:0] w_diff;
    assign w_sh         = {w_rem_a[g], w_q_a[g][XLEN-1]};
    assign w_diff       = w_sh - {1'b0, r_dvs};
    assign w_rem_a[g+1] = w_diff[XLEN] ? w_sh[XLEN-1:0] : w_diff[XLEN-1:0];
    assign w_q_a[g+1]   = {w_q_a[g][XLEN-2:0], ~w_diff[XLEN]};
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= D_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; kill overrides every transition
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      D_IDLE: begin
        if (start_i) begin
          w_state_nxt = D_INIT;
        end else begin
          w_state_nxt = D_IDLE;
        end
      end
      D_INIT: begin
        if (w_short) begin
          w_state_nxt = D_SIGN;
        end else begin
          w_state_nxt = D_CALC;
        end
      end
      D_CALC: begin
        if (r_cnt == CNT_ONE) begin
          w_state_nxt = D_SIGN;
        end else begin
          w_state_nxt = D_CALC;
        end
      end
      D_SIGN:  w_state_nxt = D_IDLE;
      default: w_state_nxt = D_IDLE;
    endcase
    if (kill_i) begin
      w_state_nxt = D_IDLE;
    end else begin
      w_state_nxt = w_state_nxt;
    end
  end

  // Sign fix-up; special-case values are already final
  always_comb begin
    w_sel_q = r_q;
    w_sel_r = r_rem;
    if (r_neg_q && !r_special) begin
      w_sel_q = ~r_q + ONE;
    end else begin
      w_sel_q = r_q;
    end
    if (r_neg_r && !r_special) begin
      w_sel_r = ~r_rem + ONE;
    end else begin
      w_sel_r = r_rem;
    end
    if (r_op[1]) begin
      w_result = w_sel_r;
    end else begin
      w_result = w_sel_q;
    end
  end

  // Datapath: capture, initialise, iterate, publish
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_op      <= 2'b00;
      r_a       <= ZERO;
      r_b       <= ZERO;
      r_q       <= ZERO;
      r_rem     <= ZERO;
      r_dvs     <= ZERO;
      r_cnt     <= {CW{1'b0}};
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_special <= 1'b0;
      r_result  <= ZERO;
      r_done    <= 1'b0;
    end else begin
      r_done <= (r_state == D_SIGN) & ~kill_i;
      case (r_state)
        D_IDLE: begin
          if (start_i && !kill_i) begin
            r_op <= op_i;
            r_a  <= rs1_i;
            r_b  <= rs2_i;
          end
        end
        D_INIT: begin
          r_dvs     <= w_abs_b;
          r_cnt     <= CNT_LOAD;
          r_neg_q   <= w_a_neg ^ w_b_neg;
          r_neg_r   <= w_a_neg;
          r_special <= w_b_zero | w_ovf;
          if (w_b_zero) begin
            r_q   <= ALL_ONES;
            r_rem <= r_a;
          end else if (w_ovf) begin
            r_q   <= MIN_INT;
            r_rem <= ZERO;
          end else if (w_fast) begin
            r_q   <= ZERO;
            r_rem <= w_abs_a;
          end else begin
            r_q   <= w_abs_a;
            r_rem <= ZERO;
          end
        end
        D_CALC: begin
          r_q   <= w_q_a[BITS_PER_CYCLE];
          r_rem <= w_rem_a[BITS_PER_CYCLE];
          r_cnt <= r_cnt - CNT_ONE;
        end
        D_SIGN: begin
          if (!kill_i) begin
            r_result <= w_result;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy_o   = (r_state != D_IDLE);
  assign done_o   = r_done;
  assign result_o = r_result;

endmodule
